// File: rtl/lock_seq_pkg.sv
// Shared definitions for the lock sequencer: state encoding, counter and
// sample widths, and the relock counter saturation value.
package lock_seq_pkg;

  localparam int DWELL_W  = 28;
  localparam int SAMPLE_W = 16;
  localparam int COUNT_W  = 16;
  localparam int FILT_W   = 8;

  localparam logic [COUNT_W-1:0] RELOCK_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SWEEP    = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

endpackage

// File: rtl/lock_seq_timer.sv
// Settle dwell timer: an up-counter held at zero while clear is high,
// advancing while enable is high. done flags the terminal count.
module lock_seq_timer
  import lock_seq_pkg::*;
#(
  parameter logic [DWELL_W-1:0] TERMINAL_COUNT = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [DWELL_W-1:0] count;

  // Dwell count; clear wins so the count reads zero on the first enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = enable && (count == TERMINAL_COUNT);

endmodule

// File: rtl/lock_sequencer.sv
// Lock sequencer: sweeps until the transmission sample is acquired, dwells
// in SETTLE with the PID running, then holds LOCKED until a filtered loss.
//
//   state    | meaning
//   DISABLED | sweep frozen, PID off; waits for enable_in
//   SWEEP    | relock sweep running, waiting for an acquired sample
//   SETTLE   | PID on, sweep frozen, dwelling SETTLE_CYCLES before lock
//   LOCKED   | PID on, sweep frozen, watching for lock loss
//
// Optional build macro LOCK_SEQ_HYST_EN: when defined the acquire threshold
// is thr_hi_in (two-threshold hysteresis); otherwise thr_lo_in serves both.
module lock_sequencer
  import lock_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 100000000,
  parameter int LOSS_FILTER   = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       enable_in,
  input  logic signed [SAMPLE_W-1:0] trans_in,
  input  logic signed [SAMPLE_W-1:0] thr_lo_in,
  input  logic signed [SAMPLE_W-1:0] thr_hi_in,
  output logic                       sweep_on_out,
  output logic                       sweep_hold_out,
  output logic                       pid_on_out,
  output logic                       pid_clear_out,
  output logic [1:0]                 state_out,
  output logic                       locked_led_out,
  output logic                       unlocked_led_out,
  output logic                       settling_led_out,
  output logic [COUNT_W-1:0]         relock_count_out
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SETTLE_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOSS_FILTER - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [FILT_W-1:0]          filt_cnt;
  logic signed [SAMPLE_W-1:0] acq_thr;
  logic                       sample_low;
  logic                       sample_acq;
  logic                       loss;
  logic                       dwell_done;
  logic                       in_settle;

`ifdef LOCK_SEQ_HYST_EN
  assign acq_thr = thr_hi_in;
`else
  // Single-threshold build: thr_hi_in is deliberately left unconnected.
  logic unused_thr_hi;
  assign unused_thr_hi = ^thr_hi_in;
  assign acq_thr = thr_lo_in;
`endif

  assign sample_low = trans_in < thr_lo_in;
  assign sample_acq = trans_in >= acq_thr;
  assign loss       = sample_low && (filt_cnt == FILT_LAST);
  assign in_settle  = (state == ST_SETTLE);
  assign state_out  = state;

  lock_seq_timer #(
    .TERMINAL_COUNT(DWELL_LAST)
  ) u_timer (
    .clk    (clk_in),
    .rst    (rst_in),
    .clear  (!in_settle),
    .enable (in_settle),
    .done   (dwell_done)
  );

  // Next-state selection; disable overrides everything, loss beats dwell completion.
  always_comb begin
    state_nxt = state;
    if (!enable_in) begin
      state_nxt = ST_DISABLED;
    end else begin
      case (state)
        ST_DISABLED: state_nxt = ST_SWEEP;
        ST_SWEEP:    if (sample_acq) state_nxt = ST_SETTLE;
        ST_SETTLE: begin
          if (loss)            state_nxt = ST_SWEEP;
          else if (dwell_done) state_nxt = ST_LOCKED;
        end
        ST_LOCKED:   if (loss) state_nxt = ST_SWEEP;
        default:     state_nxt = ST_DISABLED;
      endcase
    end
  end

  // State register with outputs decoded from the next state so they move with it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_DISABLED;
      sweep_on_out     <= 1'b0;
      sweep_hold_out   <= 1'b1;
      pid_on_out       <= 1'b0;
      pid_clear_out    <= 1'b0;
      locked_led_out   <= 1'b1;
      unlocked_led_out <= 1'b1;
      settling_led_out <= 1'b1;
    end else begin
      state            <= state_nxt;
      sweep_on_out     <= (state_nxt != ST_DISABLED);
      sweep_hold_out   <= (state_nxt != ST_SWEEP);
      pid_on_out       <= (state_nxt == ST_SETTLE) || (state_nxt == ST_LOCKED);
      pid_clear_out    <= (state == ST_SWEEP) && (state_nxt == ST_SETTLE);
      locked_led_out   <= (state_nxt != ST_LOCKED);
      settling_led_out <= (state_nxt != ST_SETTLE);
      unlocked_led_out <= !((state_nxt == ST_SWEEP) || (state_nxt == ST_DISABLED));
    end
  end

  // Consecutive-low filter; restarts on every state change and on any good sample.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      filt_cnt <= '0;
    end else if (state_nxt != state) begin
      filt_cnt <= '0;
    end else if (((state == ST_SETTLE) || (state == ST_LOCKED)) && sample_low) begin
      filt_cnt <= filt_cnt + 1'b1;
    end else begin
      filt_cnt <= '0;
    end
  end

  // Saturating count of losses out of LOCKED only.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      relock_count_out <= '0;
    end else if ((state == ST_LOCKED) && (state_nxt == ST_SWEEP) &&
                 (relock_count_out != RELOCK_SAT)) begin
      relock_count_out <= relock_count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with SETTLE_CYCLES=16, LOSS_FILTER=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lock_sequencer;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               enable_in;
  logic signed [15:0] trans_in;
  logic signed [15:0] thr_lo_in;
  logic signed [15:0] thr_hi_in;
  logic               sweep_on_out;
  logic               sweep_hold_out;
  logic               pid_on_out;
  logic               pid_clear_out;
  logic [1:0]         state_out;
  logic               locked_led_out;
  logic               unlocked_led_out;
  logic               settling_led_out;
  logic [15:0]        relock_count_out;

  int checks = 0;
  int passed = 0;

  lock_sequencer #(
    .SETTLE_CYCLES(16),
    .LOSS_FILTER  (4)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .trans_in         (trans_in),
    .thr_lo_in        (thr_lo_in),
    .thr_hi_in        (thr_hi_in),
    .sweep_on_out     (sweep_on_out),
    .sweep_hold_out   (sweep_hold_out),
    .pid_on_out       (pid_on_out),
    .pid_clear_out    (pid_clear_out),
    .state_out        (state_out),
    .locked_led_out   (locked_led_out),
    .unlocked_led_out (unlocked_led_out),
    .settling_led_out (settling_led_out),
    .relock_count_out (relock_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; enable_in = 1'b1; trans_in = 16'sd0;
    thr_lo_in = 16'sd8192; thr_hi_in = 16'sd16384;
    tick(); tick();
    checks++;
    if (state_out !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_out);
    else passed++;
    checks++;
    if ({locked_led_out, unlocked_led_out, settling_led_out} !== 3'b111)
      $display("FAIL reset_leds: got %b expected 111", {locked_led_out, unlocked_led_out, settling_led_out});
    else passed++;
    checks++;
    if ({sweep_on_out, sweep_hold_out, pid_on_out, pid_clear_out} !== 4'b0100)
      $display("FAIL reset_ctrl: got %b expected 0100", {sweep_on_out, sweep_hold_out, pid_on_out, pid_clear_out});
    else passed++;
    checks++;
    if (relock_count_out !== 16'd0) $display("FAIL reset_count: got %0d expected 0", relock_count_out);
    else passed++;
    rst_in = 1'b0;
    tick();
    checks++;
    if (state_out !== 2'd1) $display("FAIL enter_sweep_state: got %0d expected 1", state_out);
    else passed++;
    checks++;
    if ({sweep_on_out, sweep_hold_out, pid_on_out, unlocked_led_out} !== 4'b1000)
      $display("FAIL sweep_outputs: got %b expected 1000", {sweep_on_out, sweep_hold_out, pid_on_out, unlocked_led_out});
    else passed++;
  endtask

  task automatic test_acquire_settle();
    int n;
    trans_in = 16'sd10000;
    tick();
    checks++;
    if ({state_out, pid_clear_out, pid_on_out, settling_led_out} !== 5'b10110)
      $display("FAIL settle_entry: got %b expected 10110", {state_out, pid_clear_out, pid_on_out, settling_led_out});
    else passed++;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (pid_clear_out !== 1'b0) $display("FAIL pid_clear_width: got %b expected 0", pid_clear_out);
        else passed++;
      end
      if (state_out != 2'd2) break;
      n++;
    end
    checks++;
    if (n !== 16) $display("FAIL settle_length: got %0d expected 16", n);
    else passed++;
    checks++;
    if ({state_out, locked_led_out, settling_led_out, unlocked_led_out} !== 5'b11011)
      $display("FAIL locked_entry: got %b expected 11011", {state_out, locked_led_out, settling_led_out, unlocked_led_out});
    else passed++;
  endtask

  task automatic test_locked_filter();
    trans_in = 16'sd0;
    repeat (3) tick();
    checks++;
    if (state_out !== 2'd3) $display("FAIL three_lows_hold: got %0d expected 3", state_out);
    else passed++;
    trans_in = 16'sd10000;
    tick();
    checks++;
    if ({state_out, relock_count_out} !== {2'd3, 16'd0})
      $display("FAIL filter_clear: got state %0d count %0d expected 3/0", state_out, relock_count_out);
    else passed++;
    trans_in = 16'sd0;
    repeat (3) tick();
    checks++;
    if (state_out !== 2'd3) $display("FAIL restart_filter: got %0d expected 3", state_out);
    else passed++;
    tick();
    checks++;
    if ({state_out, relock_count_out} !== {2'd1, 16'd1})
      $display("FAIL locked_loss: got state %0d count %0d expected 1/1", state_out, relock_count_out);
    else passed++;
    checks++;
    if ({pid_on_out, unlocked_led_out, locked_led_out} !== 3'b001)
      $display("FAIL loss_outputs: got %b expected 001", {pid_on_out, unlocked_led_out, locked_led_out});
    else passed++;
  endtask

  task automatic test_settle_loss_at_dwell_end();
    trans_in = 16'sd10000;
    tick();
    repeat (12) tick();
    checks++;
    if (state_out !== 2'd2) $display("FAIL dwell12_state: got %0d expected 2", state_out);
    else passed++;
    trans_in = 16'sd0;
    repeat (3) tick();
    checks++;
    if (state_out !== 2'd2) $display("FAIL dwell15_state: got %0d expected 2", state_out);
    else passed++;
    tick();
    checks++;
    if ({state_out, relock_count_out} !== {2'd1, 16'd1})
      $display("FAIL loss_beats_dwell: got state %0d count %0d expected 1/1", state_out, relock_count_out);
    else passed++;
  endtask

  task automatic test_threshold_select();
    logic [1:0] exp_state;
`ifdef LOCK_SEQ_HYST_EN
    exp_state = 2'd1;
`else
    exp_state = 2'd2;
`endif
    trans_in = 16'sd12000;
    tick();
    checks++;
    if (state_out !== exp_state) $display("FAIL mid_band_acquire: got %0d expected %0d", state_out, exp_state);
    else passed++;
    trans_in = 16'sd0;
    repeat (4) tick();
    trans_in = 16'sd16384;
    tick();
    checks++;
    if (state_out !== 2'd2) $display("FAIL acquire_at_thr_hi: got %0d expected 2", state_out);
    else passed++;
    trans_in = 16'sd0;
    repeat (4) tick();
    checks++;
    if ({state_out, relock_count_out} !== {2'd1, 16'd1})
      $display("FAIL settle_loss_no_count: got state %0d count %0d expected 1/1", state_out, relock_count_out);
    else passed++;
  endtask

  task automatic test_signed_compare();
    thr_lo_in = -16'sd100; thr_hi_in = -16'sd100;
    trans_in = 16'sd50;
    tick();
    checks++;
    if (state_out !== 2'd2) $display("FAIL signed_acquire: got %0d expected 2", state_out);
    else passed++;
    trans_in = -16'sd256;
    repeat (4) tick();
    checks++;
    if (state_out !== 2'd1) $display("FAIL signed_low: got %0d expected 1", state_out);
    else passed++;
    thr_lo_in = 16'sd8192; thr_hi_in = 16'sd16384; trans_in = 16'sd0;
    tick();
  endtask

  task automatic test_saturation_and_disable();
    trans_in = 16'sd10000;
    tick();
    repeat (16) tick();
    checks++;
    if (state_out !== 2'd3) $display("FAIL relock_state: got %0d expected 3", state_out);
    else passed++;
    force dut.relock_count_out = 16'hFFFF;
    #1;
    release dut.relock_count_out;
    trans_in = 16'sd0;
    repeat (4) tick();
    checks++;
    if ({state_out, relock_count_out} !== {2'd1, 16'hFFFF})
      $display("FAIL count_saturate: got state %0d count %h expected 1/ffff", state_out, relock_count_out);
    else passed++;
    enable_in = 1'b0;
    tick();
    checks++;
    if ({state_out, sweep_on_out, sweep_hold_out, pid_on_out} !== 5'b00010)
      $display("FAIL disable: got %b expected 00010", {state_out, sweep_on_out, sweep_hold_out, pid_on_out});
    else passed++;
  endtask

  task automatic test_reset_mid_settle();
    enable_in = 1'b1; trans_in = 16'sd10000;
    tick(); tick();
    checks++;
    if (state_out !== 2'd2) $display("FAIL pre_reset_settle: got %0d expected 2", state_out);
    else passed++;
    repeat (5) tick();
    rst_in = 1'b1;
    tick();
    checks++;
    if ({state_out, pid_clear_out, locked_led_out, unlocked_led_out, settling_led_out} !== 6'b000111)
      $display("FAIL mid_reset: got %b expected 000111", {state_out, pid_clear_out, locked_led_out, unlocked_led_out, settling_led_out});
    else passed++;
    checks++;
    if (relock_count_out !== 16'd0) $display("FAIL mid_reset_count: got %0d expected 0", relock_count_out);
    else passed++;
    rst_in = 1'b0; enable_in = 1'b0;
    repeat (2) tick();
    checks++;
    if (state_out !== 2'd0) $display("FAIL stay_disabled: got %0d expected 0", state_out);
    else passed++;
    enable_in = 1'b1;
    tick();
    checks++;
    if ({state_out, pid_clear_out} !== 3'b010)
      $display("FAIL reenable: got %b expected 010", {state_out, pid_clear_out});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_acquire_settle();
    test_locked_filter();
    test_settle_loss_at_dwell_end();
    test_threshold_select();
    test_signed_compare();
    test_saturation_and_disable();
    test_reset_mid_settle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 100000000, giving the SETTLE dwell in clk_in cycles (1 s at 100 MHz); legal range 1..2^28-1.
REQ-002 The block SHALL have parameter LOSS_FILTER, default 4, giving the consecutive below-threshold samples that declare lock loss; legal range 1..255.
REQ-003 The block SHALL have port clk_in, input, 1 bit: 100 MHz system clock; the only clock.
REQ-004 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port enable_in, input, 1 bit: master enable for relock sequencing.
REQ-006 The block SHALL have port trans_in, input, 16 bits: signed transmission sample from the ADC.
REQ-007 The block SHALL have port thr_lo_in, input, 16 bits: signed lock-lost threshold.
REQ-008 The block SHALL have port thr_hi_in, input, 16 bits: signed acquire threshold, used only per REQ-026.
REQ-009 The block SHALL have port sweep_on_out, output, 1 bit: run enable for the relock sweep.
REQ-010 The block SHALL have port sweep_hold_out, output, 1 bit: freeze for the relock sweep.
REQ-011 The block SHALL have port pid_on_out, output, 1 bit: enable for the PID servo.
REQ-012 The block SHALL have port pid_clear_out, output, 1 bit: one-cycle pulse that clears the PID integrator.
REQ-013 The block SHALL have port state_out, output, 2 bits: current state encoding.
REQ-014 The block SHALL have ports locked_led_out, unlocked_led_out and settling_led_out, outputs, 1 bit each: active-low LEDs.
REQ-015 The block SHALL have port relock_count_out, output, 16 bits: saturating count of lock losses.

Function
REQ-016 Signed comparisons SHALL be used throughout.
  - Sample is "low" when trans_in < thr_lo_in.
  - Sample is "acquired" when trans_in >= acquire threshold (REQ-026).
REQ-017 States SHALL be DISABLED=0, SWEEP=1, SETTLE=2, LOCKED=3; all outputs are decoded from the registered state and change on the edge that updates the state.
REQ-018 Highest priority: enable_in=0 SHALL force DISABLED at the next edge from any state.
REQ-019 In DISABLED:
  - outputs: sweep_on=0, sweep_hold=1, pid_on=0.
  - transition: enable_in=1 goes to SWEEP.
REQ-020 In SWEEP:
  - outputs: sweep_on=1, sweep_hold=0, pid_on=0.
  - transition: an acquired sample goes to SETTLE, and pid_clear_out pulses high for exactly the first SETTLE cycle.
REQ-021 In SETTLE:
  - outputs: sweep_on=1, sweep_hold=1, pid_on=1.
  - dwell counter (28 bits) is zeroed on entry and increments each cycle.
  - on count == SETTLE_CYCLES-1 with no loss: goes to LOCKED.
REQ-022 In LOCKED:
  - outputs: same as SETTLE.
  - on loss: goes to SWEEP and increments relock_count_out, saturating at 16'hFFFF.
REQ-023 Loss filter:
  - counts consecutive low samples in SETTLE and LOCKED.
  - clears on any non-low sample and on every state entry.
  - "loss" = count reaches LOSS_FILTER.
  - loss in SETTLE goes to SWEEP without incrementing relock_count_out.
REQ-024 Simultaneous loss and dwell completion in SETTLE SHALL resolve to SWEEP.
REQ-025 LED mapping: locked_led_out=0 only in LOCKED; settling_led_out=0 only in SETTLE; unlocked_led_out=0 in SWEEP and DISABLED.

Reset
REQ-026 Acquire threshold selection:
  - LOCK_SEQ_HYST_EN defined: acquire threshold = thr_hi_in.
  - LOCK_SEQ_HYST_EN undefined: acquire threshold = thr_lo_in, and thr_hi_in is ignored.
REQ-027 rst_in=1 at an edge SHALL set:
  - state to DISABLED.
  - dwell and filter counters to 0.
  - relock_count_out to 0.
  - pid_clear_out to 0.
  - LEDs all 1.
REQ-028 Reset mid-operation SHALL abort any SETTLE dwell with no pid_clear pulse, and re-entry requires enable_in=1 after rst_in falls.

Configuration
REQ-029 Macro LOCK_SEQ_HYST_EN:
  - defined: two-threshold hysteresis per REQ-026.
  - undefined: single threshold, and no logic may depend on thr_hi_in.

Structure
REQ-030 Shared package lock_seq_pkg SHALL hold:
  - state encoding constants.
  - 28-bit dwell counter width.
  - 16-bit sample width.
  - relock count saturation value.
REQ-031 The dwell counter SHALL be a sub-module lock_seq_timer with these ports:
  - clear input.
  - enable input.
  - terminal-count parameter.
  - done output.

Verification
REQ-032 The bench SHALL run with SETTLE_CYCLES=16 and LOSS_FILTER=4 and cover these scenarios:
  - Reset with enable=1 and trans=0: state_out 0 then 1, sweep_on=1, pid_on=0, unlocked_led=0.
  - thr_lo=8192, trans steps 0->10000 in SWEEP: pid_clear pulses exactly 1 cycle, state 2 for 16 cycles then 3, locked_led=0.
  - In LOCKED, trans=0 for 3 cycles then 10000: stays LOCKED with count 0; trans=0 for 4 cycles: SWEEP, count=1.
  - In SETTLE, loss on the cycle dwell hits 15: state goes to SWEEP and count is unchanged.
  - With HYST_EN, thr_lo=8192, thr_hi=16384, trans=12000: stays SWEEP. Without HYST_EN, the same stimulus enters SETTLE.
  - Count forced to 16'hFFFF then a further loss: count stays 16'hFFFF. Then enable=0: state 0 next edge, pid_on=0.
